tlc_timed_2way: RTL and testbench

//  Parametrised two-road traffic light controller for the lab traffic-light designs.
//  - Moore FSM with an all-red clearance phase.
//  - Programmable minimum green, maximum green, yellow and all-red durations.
//  - Alternating-priority arbitration when both roads request at once.
//  - Sits between the road sensors (Ta, Tb) and the lamp drivers (La, Lb).

---
 rtl/tlc_timed_2way.sv | 113 +++++++++++
 tb/tb_tlc_timed_2way.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_timed_2way.sv
// Two-road timed traffic light controller.
// Moore FSM with all-red clearance and alternating tie-break.
module tlc_timed_2way #(
  parameter int CW        = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [2:0] phase,
  output logic       last_served
);

  localparam logic [2:0] ALLRED = 3'b000;
  localparam logic [2:0] A_GRN  = 3'b001;
  localparam logic [2:0] A_YEL  = 3'b010;
  localparam logic [2:0] B_GRN  = 3'b011;
  localparam logic [2:0] B_YEL  = 3'b100;

  localparam logic [1:0] GRN = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] RED = 2'b10;

  // Thresholds are "last cycle" values of tmr.
  localparam logic [CW-1:0] T_MIN = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] T_MAX = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] T_YEL = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] T_AR  = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [CW-1:0] tmr;
  logic          ls_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ALLRED;
      tmr         <= '0;
      last_served <= 1'b1;
    end else begin
      state       <= state_n;
      last_served <= ls_n;
      if (state_n != state)
        tmr <= '0;
      else if (tmr != '1)
        tmr <= tmr + ONE;
    end
  end

  always_comb begin
    state_n = state;
    ls_n    = last_served;
    case (state)
      ALLRED: begin
        if (tmr >= T_AR && (Ta || Tb)) begin
          if (Ta && Tb)
            state_n = last_served ? A_GRN : B_GRN;
          else if (Ta)
            state_n = A_GRN;
          else
            state_n = B_GRN;
        end
      end
      A_GRN: begin
        if (tmr >= T_MIN &&
            (!Ta || (Tb && tmr >= T_MAX)))
          state_n = A_YEL;
      end
      A_YEL: begin
        if (tmr >= T_YEL) begin
          state_n = ALLRED;
          ls_n    = 1'b0;
        end
      end
      B_GRN: begin
        if (tmr >= T_MIN &&
            (!Tb || (Ta && tmr >= T_MAX)))
          state_n = B_YEL;
      end
      B_YEL: begin
        if (tmr >= T_YEL) begin
          state_n = ALLRED;
          ls_n    = 1'b1;
        end
      end
      default: state_n = ALLRED;
    endcase
  end

  always_comb begin
    La    = RED;
    Lb    = RED;
    phase = state;
    case (state)
      A_GRN:   La = GRN;
      A_YEL:   La = YEL;
      B_GRN:   Lb = GRN;
      B_YEL:   Lb = YEL;
      default: begin
        La = RED;
        Lb = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_tlc_timed_2way.sv
// Directed bench for tlc_timed_2way.
// Scenario tasks with inline checks plus a lamp legality monitor.
module tb_tlc_timed_2way;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Ta = 1'b0;
  logic       Tb = 1'b0;
  logic [1:0] La;
  logic [1:0] Lb;
  logic [2:0] phase;
  logic       last_served;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  tlc_timed_2way dut (
    .clk(clk),
    .reset(reset),
    .Ta(Ta),
    .Tb(Tb),
    .La(La),
    .Lb(Lb),
    .phase(phase),
    .last_served(last_served)
  );

  // Expected {La,Lb} for a phase code.
  function automatic logic [3:0] lamps(input logic [2:0] ph);
    case (ph)
      3'd1:    return 4'b0010;
      3'd2:    return 4'b0110;
      3'd3:    return 4'b1000;
      3'd4:    return 4'b1001;
      default: return 4'b1010;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    Ta = 1'b0;
    Tb = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((La != 2'b10 && Lb != 2'b10) ||
          phase > 3'd4) begin
        errors++;
        $display("FAIL monitor: La=%b Lb=%b phase=%0d required a red lamp and phase<=4",
                 La, Lb, phase);
      end
    end
  end

  task automatic test_reset;
    reset = 1'b0;
    Ta = 1'b0;
    Tb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      mon_en = 1'b1;
      checks++;
      if ({phase, La, Lb, last_served} !== {3'd0, 4'b1010, 1'b1}) begin
        errors++;
        $display("FAIL reset_hold: phase=%0d La=%b Lb=%b ls=%b required 0 10 10 1",
                 phase, La, Lb, last_served);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({phase, La, Lb} !== {3'd0, 4'b1010}) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d phase=%0d La=%b Lb=%b required 0 10 10",
                 i, phase, La, Lb);
      end
    end
  endtask

  task automatic test_a_only;
    logic [2:0] exp [11] = '{0, 1, 1, 1, 1, 2, 2, 2, 0, 0, 0};
    do_reset();
    Ta = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if ({phase, La, Lb} !== {exp[i], lamps(exp[i])}) begin
        errors++;
        $display("FAIL a_only: cycle %0d phase=%0d lamps=%b required %0d %b",
                 i, phase, {La, Lb}, exp[i], lamps(exp[i]));
      end
      if (i == 2) Ta = 1'b0;
    end
    checks++;
    if (last_served !== 1'b0) begin
      errors++;
      $display("FAIL a_only_ls: last_served=%b required 0", last_served);
    end
  endtask

  task automatic test_reset_mid_yellow;
    logic [2:0] exp [6] = '{1, 1, 1, 1, 2, 2};
    Ta = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (phase !== exp[i]) begin
        errors++;
        $display("FAIL mid_yel_run: cycle %0d phase=%0d required %0d",
                 i, phase, exp[i]);
      end
      if (i == 0) Ta = 1'b0;
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({phase, La, Lb, last_served} !== {3'd0, 4'b1010, 1'b1}) begin
      errors++;
      $display("FAIL mid_yel_reset: phase=%0d lamps=%b ls=%b required 0 1010 1",
               phase, {La, Lb}, last_served);
    end
    reset = 1'b1;
    Ta = 1'b1;
    Tb = 1'b1;
    tick();
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL mid_yel_clear: phase=%0d required 0", phase);
    end
    tick();
    checks++;
    if (phase !== 3'd1) begin
      errors++;
      $display("FAIL mid_yel_tie: phase=%0d required 1", phase);
    end
    Ta = 1'b0;
    Tb = 1'b0;
  endtask

  task automatic test_both;
    logic [2:0] q [$];
    q.push_back(3'd0);
    for (int r = 0; r < 2; r++) begin
      repeat (12) q.push_back(3'd1);
      repeat (3)  q.push_back(3'd2);
      repeat (2)  q.push_back(3'd0);
      repeat (12) q.push_back(3'd3);
      repeat (3)  q.push_back(3'd4);
      repeat (2)  q.push_back(3'd0);
    end
    q.push_back(3'd1);
    do_reset();
    Ta = 1'b1;
    Tb = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      tick();
      checks++;
      if ({phase, La, Lb} !== {q[i], lamps(q[i])}) begin
        errors++;
        $display("FAIL both: cycle %0d phase=%0d lamps=%b required %0d %b",
                 i, phase, {La, Lb}, q[i], lamps(q[i]));
      end
    end
    checks++;
    if (last_served !== 1'b1) begin
      errors++;
      $display("FAIL both_ls: last_served=%b required 1", last_served);
    end
    Ta = 1'b0;
    Tb = 1'b0;
  endtask

  task automatic test_saturation;
    logic [2:0] exp [4] = '{2, 2, 2, 0};
    do_reset();
    Ta = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 310; i++) begin
      checks++;
      if (phase !== 3'd1) begin
        errors++;
        $display("FAIL sat_hold: cycle %0d phase=%0d required 1", i, phase);
      end
      tick();
    end
    Tb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (phase !== exp[i]) begin
        errors++;
        $display("FAIL sat_yel: cycle %0d phase=%0d required %0d",
                 i, phase, exp[i]);
      end
    end
    Ta = 1'b0;
    Tb = 1'b0;
  endtask

  task automatic test_sim_change;
    logic [2:0] pre [5] = '{0, 1, 1, 1, 1};
    logic [2:0] post [6] = '{2, 2, 2, 0, 0, 3};
    do_reset();
    Ta = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (phase !== pre[i]) begin
        errors++;
        $display("FAIL sim_pre: cycle %0d phase=%0d required %0d",
                 i, phase, pre[i]);
      end
    end
    Ta = 1'b0;
    Tb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({phase, La, Lb} !== {post[i], lamps(post[i])}) begin
        errors++;
        $display("FAIL sim_post: cycle %0d phase=%0d lamps=%b required %0d %b",
                 i, phase, {La, Lb}, post[i], lamps(post[i]));
      end
    end
    Tb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_reset_mid_yellow();
    test_both();
    test_saturation();
    test_sim_change();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
